// File: rtl/brus16_pkg.sv
// Shared types and constants for the brus16 program loader.
// CODE_LOADER_CHECKSUM_EN adds the trailing checksum states.
package brus16_pkg;

  localparam int CODE_WIDTH_DEF = 13;
  localparam int LEN_BYTES      = 2;
  localparam int CHK_BYTES      = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
`ifdef CODE_LOADER_CHECKSUM_EN
    ,
    ST_CHK_LO,
    ST_CHK_HI
`endif
  } ld_state_e;

endpackage

// File: rtl/byte_pair_assembler.sv
// Joins a little-endian lo/hi byte pair into one 16-bit word.
// Used for the length, data and checksum fields.
module byte_pair_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic        byte_hi,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic        word_valid
);

  logic [7:0] lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
    end else if (clear) begin
      lo_q <= '0;
    end else if (byte_en && !byte_hi) begin
      lo_q <= byte_in;
    end
  end

  // word is valid in the same cycle the high byte is accepted
  assign word       = {byte_in, lo_q};
  assign word_valid = byte_en & byte_hi;

endmodule

// File: rtl/code_loader.sv
// Streams a length-prefixed 16-bit image into program memory.
// CODE_LOADER_CHECKSUM_EN appends a verified sum word.
module code_loader
  import brus16_pkg::*;
#(
  parameter int CODE_WIDTH = CODE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_din_we,
  output logic [CODE_WIDTH-1:0] mem_din_addr,
  output logic [15:0]           mem_din,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int IW = CODE_WIDTH + 1;
  localparam logic [16:0] MAX_N = 17'd1 << CODE_WIDTH;

  ld_state_e     state;
  logic [15:0]   len_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_nxt;
  logic          accept;
  logic          hi_sel;
  logic          start_ok;
  logic          last_word;
  logic [15:0]   word;
  logic          word_valid;

  assign accept  = rx_valid & rx_ready;
  assign idx_nxt = idx_q + {{(IW-1){1'b0}}, 1'b1};
  assign last_word =
    {{(17-IW){1'b0}}, idx_nxt} == {1'b0, len_q};

  assign start_ok = start &
    ((state == ST_IDLE) | (state == ST_DONE) |
     (state == ST_ERROR));

`ifdef CODE_LOADER_CHECKSUM_EN
  assign hi_sel = (state == ST_LEN_HI) |
                  (state == ST_DATA_HI) |
                  (state == ST_CHK_HI);
`else
  assign hi_sel = (state == ST_LEN_HI) |
                  (state == ST_DATA_HI);
`endif

  byte_pair_assembler u_bpa (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (start_ok),
    .byte_en    (accept),
    .byte_hi    (hi_sel),
    .byte_in    (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

`ifdef CODE_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (state == ST_DATA_HI && word_valid) begin
      sum_q <= sum_q + word;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      rx_ready     <= 1'b0;
      mem_din_we   <= 1'b0;
      mem_din_addr <= '0;
      mem_din      <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      idx_q        <= '0;
      len_q        <= '0;
    end else begin
      mem_din_we <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state        <= ST_LEN_LO;
            rx_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            mem_din_addr <= '0;
            idx_q        <= '0;
            len_q        <= '0;
          end
        end
        ST_LEN_LO: begin
          if (accept) state <= ST_LEN_HI;
        end
        ST_LEN_HI: begin
          if (word_valid) begin
            len_q <= word;
            if (word == 16'd0) begin
`ifdef CODE_LOADER_CHECKSUM_EN
              state    <= ST_CHK_LO;
`else
              state    <= ST_DONE;
              rx_ready <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
`endif
            end else if ({1'b0, word} > MAX_N) begin
              state    <= ST_ERROR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= ST_DATA_LO;
            end
          end
        end
        ST_DATA_LO: begin
          if (accept) state <= ST_DATA_HI;
        end
        ST_DATA_HI: begin
          if (word_valid) begin
            state        <= ST_WRITE;
            rx_ready     <= 1'b0;
            mem_din_we   <= 1'b1;
            mem_din      <= word;
            mem_din_addr <= idx_q[CODE_WIDTH-1:0];
          end
        end
        ST_WRITE: begin
          idx_q    <= idx_nxt;
          rx_ready <= 1'b1;
          if (last_word) begin
`ifdef CODE_LOADER_CHECKSUM_EN
            state    <= ST_CHK_LO;
`else
            state    <= ST_DONE;
            rx_ready <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
`endif
          end else begin
            state <= ST_DATA_LO;
          end
        end
`ifdef CODE_LOADER_CHECKSUM_EN
        ST_CHK_LO: begin
          if (accept) state <= ST_CHK_HI;
        end
        ST_CHK_HI: begin
          if (word_valid) begin
            rx_ready <= 1'b0;
            if (word == sum_q) begin
              state    <= ST_DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= ST_IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Directed plus randomized bench for code_loader (CODE_WIDTH=4).
// Honors CODE_LOADER_CHECKSUM_EN when the build defines it.
module tb_code_loader;

  localparam int CW = 4;
  localparam int DEPTH = 1 << CW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          mem_din_we;
  logic [CW-1:0] mem_din_addr;
  logic [15:0]   mem_din;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;
  bit bp = 1'b0;

  logic [15:0] shadow [DEPTH];
  int          wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  logic [15:0] img [$];

  code_loader #(.CODE_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_din_we   (mem_din_we),
    .mem_din_addr (mem_din_addr),
    .mem_din      (mem_din),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Program-memory model: records every write strobe
  always @(negedge clk) begin
    if (reset && mem_din_we === 1'b1) begin
      wr_addr_q.push_back(int'(mem_din_addr));
      wr_data_q.push_back(mem_din);
      shadow[mem_din_addr] = mem_din;
      check("we_rx_ready_low", {31'd0, rx_ready}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    if (bp) begin
      while ($urandom_range(0, 2) == 0 && w < 5) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
        w++;
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    w = 0;
    while (rx_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("rx_accept_timeout", {31'd0, w < 50}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_load(input int n, input bit bad_chk,
                          input bit early);
    logic [15:0] sum = 16'd0;
    logic [15:0] c;
    bit exp_err;
    int nw;
    int to = 0;
    foreach (img[i]) sum += img[i];
    @(negedge clk);
    start = 1'b1;
    if (early) begin
      rx_valid = 1'b1;
      rx_data  = n[7:0];
    end
    @(negedge clk);
    start = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    check("busy_hold", {31'd0, cpu_hold}, 32'd1);
    check("busy_done", {31'd0, done}, 32'd0);
    check("busy_ready", {31'd0, rx_ready}, 32'd1);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    exp_err = n > DEPTH;
    nw = exp_err ? 0 : n;
`ifndef CODE_LOADER_CHECKSUM_EN
    if (n == 0) check("empty_done_fast", {31'd0, done}, 32'd1);
`endif
    if (exp_err) check("oversize_err_fast", {31'd0, error}, 32'd1);
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        send_byte(img[i][7:0]);
        send_byte(img[i][15:8]);
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      c = bad_chk ? sum + 16'd1 : sum;
      send_byte(c[7:0]);
      send_byte(c[15:8]);
      exp_err = bad_chk;
`else
      c = sum;
`endif
    end
    while (done !== 1'b1 && error !== 1'b1 && to < 20) begin
      @(negedge clk);
      to++;
    end
    check("finish_timeout", {31'd0, to < 20}, 32'd1);
    check("done", {31'd0, done}, {31'd0, !exp_err});
    check("error", {31'd0, error}, {31'd0, exp_err});
    check("cpu_hold", {31'd0, cpu_hold}, {31'd0, exp_err});
    check("write_count", wr_addr_q.size(), nw);
    for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
      check("write_addr", wr_addr_q[i], i);
      check("write_data", {16'd0, wr_data_q[i]}, {16'd0, img[i]});
    end
    if (nw > 0)
      check("fetch_addr0", {16'd0, shadow[0]}, {16'd0, img[0]});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_we", {31'd0, mem_din_we}, 32'd0);
    check("rst_addr", {28'd0, mem_din_addr}, 32'd0);
    check("rst_din", {16'd0, mem_din}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", {31'd0, rx_ready}, 32'd0);

    // basic image; first length byte already valid with start
    img = '{16'h1234, 16'h5678, 16'h9ABC};
    run_load(3, 1'b0, 1'b1);

    img = '{};
    run_load(0, 1'b0, 1'b0);

    run_load(17, 1'b0, 1'b0);
    img = '{16'hBEEF};
    run_load(1, 1'b0, 1'b0);

    img = '{};
    for (int i = 0; i < DEPTH; i++) img.push_back(16'($urandom));
    run_load(DEPTH, 1'b0, 1'b0);

    bp = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n = $urandom_range(1, DEPTH);
      img = '{};
      for (int i = 0; i < n; i++) img.push_back(16'($urandom));
      run_load(n, 1'b0, 1'b0);
    end
    bp = 1'b0;

`ifdef CODE_LOADER_CHECKSUM_EN
    img = '{16'h0001, 16'h0002};
    run_load(2, 1'b1, 1'b0);
    run_load(2, 1'b0, 1'b0);
`endif

    // abort after the second word lands
    img = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'd4);
    send_byte(8'd0);
    for (int i = 0; i < 2; i++) begin
      send_byte(img[i][7:0]);
      send_byte(img[i][15:8]);
    end
    @(negedge clk);
    check("mid_writes", wr_addr_q.size(), 2);
    reset = 1'b0;
    #1;
    check("mid_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("mid_we", {31'd0, mem_din_we}, 32'd0);
    check("mid_addr", {28'd0, mem_din_addr}, 32'd0);
    check("mid_din", {16'd0, mem_din}, 32'd0);
    check("mid_hold", {31'd0, cpu_hold}, 32'd1);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_error", {31'd0, error}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    img = '{16'h4321};
    run_load(1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
